// File: rtl/tq_tbuf_ctrl.sv
// -----------------------------------------------------------------------------
// tq_tbuf_ctrl
// Transpose-buffer controller for the TQ path. One 32-coefficient block
// (8 rows x 4 cols, row-major) is written into a 32-word single-port SRAM,
// then read back either column-major (transposed) or in linear order for
// the second transform pass.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   in_valid_i     : input coefficient valid
//   in_ready_o     : controller accepts a coefficient (fill phase)
//   in_data_i      : input coefficient
//   in_mode_i      : 0 = transposed, 1 = linear readback (taken with word 0)
//   out_valid_o    : output coefficient valid
//   out_ready_i    : downstream accepts
//   out_data_o     : output coefficient
//   out_last_o     : marks the 32nd output word of a block
//   mem_cen_o      : SRAM chip enable, active low
//   mem_oen_o      : SRAM output enable, active low, tied 0
//   mem_wen_o      : SRAM write enable, active low
//   mem_addr_o     : SRAM address
//   mem_data_o     : SRAM write data
//   mem_data_i     : SRAM read data, valid one cycle after a read access
// -----------------------------------------------------------------------------
module tq_tbuf_ctrl #(
    parameter int Word_Width = 16,
    parameter int Addr_Width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [Word_Width-1:0] in_data_i,
    input  logic                  in_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [Word_Width-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  mem_cen_o,
    output logic                  mem_oen_o,
    output logic                  mem_wen_o,
    output logic [Addr_Width-1:0] mem_addr_o,
    output logic [Word_Width-1:0] mem_data_o,
    input  logic [Word_Width-1:0] mem_data_i
);

    typedef enum logic [0:0] {
        ST_WR = 1'b0,
        ST_RD = 1'b1
    } state_e;

    state_e                  state_q;
    logic [Addr_Width-1:0]   wr_cnt_q;
    logic [Addr_Width:0]     rd_cnt_q;      // extra MSB flags "all 32 reads issued"
    logic [Addr_Width-1:0]   pop_cnt_q;
    logic                    mode_q;
    logic                    rd_vld_q;      // a read was issued last cycle; data arrives now
    logic [Word_Width-1:0]   fifo_mem_q [0:1];
    logic                    fifo_wptr_q;
    logic                    fifo_rptr_q;
    logic [1:0]              fifo_cnt_q;
    logic [Addr_Width-1:0]   mem_addr_q;
    logic [Word_Width-1:0]   mem_data_q;

    logic                    wr_fire_s;
    logic                    pop_s;
    logic                    push_s;
    logic [1:0]              occ_s;
    logic                    rd_issue_s;
    logic [Addr_Width-1:0]   rd_addr_s;

    // Handshake, read-issue decision and SRAM port drive.
    always_comb begin
        wr_fire_s  = (state_q == ST_WR) && in_valid_i;
        pop_s      = (fifo_cnt_q != 2'd0) && out_ready_i;
        push_s     = rd_vld_q;
        // Buffered words after this cycle's pop plus the read still in flight.
        occ_s      = fifo_cnt_q - {1'b0, pop_s} + {1'b0, rd_vld_q};
        rd_issue_s = (state_q == ST_RD) && !rd_cnt_q[Addr_Width] && (occ_s < 2'd2);
        // Transposed order walks the 8x4 block column by column: k[2:0]*4 + k[4:3].
        if (mode_q) begin
            rd_addr_s = rd_cnt_q[Addr_Width-1:0];
        end else begin
            rd_addr_s = {rd_cnt_q[2:0], rd_cnt_q[4:3]};
        end

        mem_cen_o = !(wr_fire_s || rd_issue_s);
        mem_wen_o = !wr_fire_s;
        mem_oen_o = 1'b0;
        // Address and write data hold their last value on idle cycles.
        if (wr_fire_s) begin
            mem_addr_o = wr_cnt_q;
            mem_data_o = in_data_i;
        end else if (rd_issue_s) begin
            mem_addr_o = rd_addr_s;
            mem_data_o = mem_data_q;
        end else begin
            mem_addr_o = mem_addr_q;
            mem_data_o = mem_data_q;
        end
    end

    assign in_ready_o  = (state_q == ST_WR);
    assign out_valid_o = (fifo_cnt_q != 2'd0);
    assign out_data_o  = fifo_mem_q[fifo_rptr_q];
    assign out_last_o  = (fifo_cnt_q != 2'd0) && (pop_cnt_q == 5'd31);

    // FSM, counters, output FIFO and SRAM address/data hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WR;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            pop_cnt_q     <= '0;
            mode_q        <= 1'b0;
            rd_vld_q      <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wptr_q   <= 1'b0;
            fifo_rptr_q   <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
        end else begin
            mem_addr_q <= mem_addr_o;
            mem_data_q <= mem_data_o;
            rd_vld_q   <= rd_issue_s;

            if (push_s) begin
                fifo_mem_q[fifo_wptr_q] <= mem_data_i;
                fifo_wptr_q             <= ~fifo_wptr_q;
            end
            if (pop_s) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};

            case (state_q)
                ST_WR: begin
                    if (wr_fire_s) begin
                        wr_cnt_q <= wr_cnt_q + 5'd1;   // wraps to 0 after word 31
                        if (wr_cnt_q == 5'd0) begin
                            mode_q <= in_mode_i;
                        end
                        if (wr_cnt_q == 5'd31) begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_issue_s) begin
                        rd_cnt_q <= rd_cnt_q + 6'd1;
                    end
                    if (pop_s) begin
                        pop_cnt_q <= pop_cnt_q + 5'd1;
                        if (pop_cnt_q == 5'd31) begin
                            state_q  <= ST_WR;
                            rd_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_WR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tq_tbuf_ctrl.sv
module tb_tq_tbuf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        in_mode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        mem_cen_o;
    logic        mem_oen_o;
    logic        mem_wen_o;
    logic [4:0]  mem_addr_o;
    logic [15:0] mem_data_o;
    logic [15:0] mem_data_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [16:0] exp_q [$];   // {last, data}

    tq_tbuf_ctrl #(.Word_Width(16), .Addr_Width(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_mode_i(in_mode_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o),
        .mem_cen_o(mem_cen_o), .mem_oen_o(mem_oen_o), .mem_wen_o(mem_wen_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // SRAM model plus bookkeeping of writes, overlap violations and outstanding words.
    logic [15:0] sram [0:31];
    logic [15:0] rdata = 16'h0;
    int wr_tot = 0;
    int rd_tot = 0;
    int pop_tot = 0;
    int ovl = 0;
    int max_out = 0;
    logic rd_now, wr_now, pop_now;
    int outst;
    assign rd_now  = (mem_cen_o === 1'b0) && (mem_wen_o === 1'b1);
    assign wr_now  = (mem_cen_o === 1'b0) && (mem_wen_o === 1'b0);
    assign pop_now = (out_valid_o === 1'b1) && (out_ready_i === 1'b1);
    assign outst   = rd_tot + int'(rd_now) - pop_tot - int'(pop_now);
    assign mem_data_i = rdata;

    always @(posedge clk) begin
        if (rst) begin
            rd_tot <= pop_tot;
        end else begin
            if (wr_now) begin
                sram[mem_addr_o] <= mem_data_o;
                wr_tot <= wr_tot + 1;
                if (in_ready_o !== 1'b1) ovl <= ovl + 1;
            end
            if (rd_now) begin
                rdata <= sram[mem_addr_o];
                if (in_ready_o !== 1'b0) ovl <= ovl + 1;
            end
            rd_tot  <= rd_tot + int'(rd_now);
            pop_tot <= pop_tot + int'(pop_now);
            if (outst > max_out) max_out <= outst;
        end
    end

    // Write one block, push its expected readback, then drain and score it.
    task automatic run_block(input logic mode, input int gap, input int rdy_pct,
                             input bit toggle, input bit rnd, input bit chk_lat,
                             input string tag);
        logic [15:0] d [0:31];
        logic [4:0]  kk;
        logic [4:0]  a;
        logic [16:0] e;
        logic [16:0] held;
        bit          held_v;
        bit          done;
        bit          rdy;
        int          c;
        int          first_v;
        for (int i = 0; i < 32; i++) d[i] = rnd ? 16'($urandom) : 16'(i);

        for (int i = 0; i < 32; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid_i = 1'b0;
                    #1;
                    n_chk++;
                    if (mem_cen_o !== 1'b1 || in_ready_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s gap_idle: cen=%b rdy=%b required cen=1 rdy=1", tag, mem_cen_o, in_ready_o);
                    end
                    @(negedge clk);
                end
            end
            n_chk++;
            if (in_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s in_ready word %0d: got %b required 1", tag, i, in_ready_o);
            end
            in_valid_i = 1'b1;
            in_data_i  = d[i];
            in_mode_i  = (i == 0) ? mode : (toggle ? ~mode : mode);
            #1;
            n_chk++;
            if (mem_cen_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_addr_o !== 5'(i) || mem_data_o !== d[i]) begin
                n_fail++;
                $display("FAIL %s sram_write %0d: cen=%b wen=%b addr=%0d data=%h required 0 0 %0d %h",
                         tag, i, mem_cen_o, mem_wen_o, mem_addr_o, mem_data_o, i, d[i]);
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;

        for (int k = 0; k < 32; k++) begin
            kk = 5'(k);
            a  = mode ? kk : {kk[2:0], kk[4:3]};
            exp_q.push_back({(k == 31), d[a]});
        end

        c = 0; done = 0; held_v = 0; first_v = -1; held = '0;
        while (!done && c < 400) begin
            rdy = ($urandom_range(99) < rdy_pct);
            out_ready_i = rdy;
            n_chk++;
            if (in_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s in_ready_rd c=%0d: got %b required 0", tag, c, in_ready_o);
            end
            if (held_v) begin
                n_chk++;
                if (out_valid_o !== 1'b1 || {out_last_o, out_data_o} !== held) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: valid=%b got %h required %h", tag, out_valid_o, {out_last_o, out_data_o}, held);
                end
            end
            if (out_valid_o === 1'b1 && first_v < 0) first_v = c;
            if (out_valid_o === 1'b1 && rdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                n_chk++;
                if ({out_last_o, out_data_o} !== e) begin
                    n_fail++;
                    $display("FAIL %s out_word: got last=%b data=%h required last=%b data=%h",
                             tag, out_last_o, out_data_o, e[16], e[15:0]);
                end
                if (e[16]) begin
                    done = 1;
                    if (chk_lat) begin
                        n_chk++;
                        if (first_v != 2 || c != 33) begin
                            n_fail++;
                            $display("FAIL %s latency: first_valid=%0d last_pop=%0d required 2 33", tag, first_v, c);
                        end
                    end
                end
                held_v = 0;
            end else if (out_valid_o === 1'b1) begin
                held_v = 1;
                held   = {out_last_o, out_data_o};
            end else begin
                held_v = 0;
            end
            @(negedge clk);
            c++;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s drain_timeout: got %0d cycles without last word, required completion", tag, c);
        end
        n_chk++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_wr: in_ready=%b out_valid=%b required 1 0", tag, in_ready_o, out_valid_o);
        end
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_mode_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({in_ready_o, out_valid_o, out_last_o, mem_cen_o, mem_wen_o, mem_oen_o} !== 6'b100110 ||
            mem_addr_o !== 5'd0 || mem_data_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/last/cen/wen/oen=%b addr=%0d data=%h required 100110 0 0000",
                     {in_ready_o, out_valid_o, out_last_o, mem_cen_o, mem_wen_o, mem_oen_o}, mem_addr_o, mem_data_o);
        end
        @(negedge clk);
        // Fill a block, start draining, then reset in the middle of RD.
        for (int i = 0; i < 32; i++) begin
            in_valid_i = 1'b1; in_data_i = 16'(16'h100 + i);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || mem_cen_o !== 1'b1 || out_last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rd_reset: rdy=%b vld=%b cen=%b last=%b required 1 0 1 0", in_ready_o, out_valid_o, mem_cen_o, out_last_o);
        end
        @(negedge clk);
        run_block(1'b1, 0, 100, 1'b0, 1'b1, 1'b0, "rst_restart");
    endtask

    task automatic test_transpose();
        run_block(1'b0, 0, 100, 1'b0, 1'b0, 1'b1, "transpose");
    endtask

    task automatic test_linear();
        run_block(1'b1, 0, 100, 1'b1, 1'b0, 1'b1, "linear");
    endtask

    task automatic test_backpressure();
        run_block(1'b0, 0, 50, 1'b0, 1'b0, 1'b0, "bp_transpose");
        run_block(1'b1, 0, 50, 1'b0, 1'b1, 1'b0, "bp_linear");
        n_chk++;
        if (max_out > 2) begin
            n_fail++;
            $display("FAIL bp_outstanding: got %0d required <= 2", max_out);
        end
    endtask

    task automatic test_input_gaps();
        int w0;
        w0 = wr_tot;
        run_block(1'b0, 2, 100, 1'b0, 1'b1, 1'b0, "gaps");
        n_chk++;
        if (wr_tot - w0 != 32) begin
            n_fail++;
            $display("FAIL gaps_write_count: got %0d required 32", wr_tot - w0);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 4; b++) begin
            run_block(b[0], 0, (b < 2) ? 100 : 60, 1'b0, 1'b1, 1'b0, "b2b");
        end
        n_chk++;
        if (ovl != 0) begin
            n_fail++;
            $display("FAIL b2b_overlap: got %0d rd/wr overlaps required 0", ovl);
        end
        n_chk++;
        if (max_out > 2) begin
            n_fail++;
            $display("FAIL b2b_outstanding: got %0d required <= 2", max_out);
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_linear();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
